// File: rtl/instr_fetch.sv
// Fetch stage: owns PC and IR, handshakes with a variable-latency instruction memory,
// and selects the next PC from the decoder's branch/jump and the ALU zero flag.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  input  logic        done,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, ERR} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [31:0]        pc_nx, instr_nx, next_pc;
  logic               valid_nx, err_nx, req_nx;

  assign op        = instr[31:26];
  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  // Next PC: jump beats branch; branch offset is a sign-extended word offset
  always_comb begin
    next_pc = pc_plus4;
    if (jump)
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (branch && zero)
      next_pc = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      imem_req    <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      pc          <= pc_nx;
      instr       <= instr_nx;
      instr_valid <= valid_nx;
      fetch_err   <= err_nx;
      imem_req    <= req_nx;
    end
  end

  // imem_req is registered, so it is set whenever the next state is FETCH
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pc_nx    = pc;
    instr_nx = instr;
    valid_nx = instr_valid;
    err_nx   = fetch_err;
    req_nx   = 1'b0;
    case (state)
      IDLE: begin
        state_nx = FETCH;
        cnt_nx   = '0;
        req_nx   = 1'b1;
      end
      FETCH: begin
        if (imem_ack) begin
          instr_nx = imem_rdata;
          valid_nx = 1'b1;
          cnt_nx   = '0;
          state_nx = EXEC;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          err_nx   = 1'b1;
          state_nx = ERR;
        end else begin
          cnt_nx   = cnt + CNT_W'(1);
          req_nx   = 1'b1;
        end
      end
      EXEC: begin
        if (done) begin
          pc_nx    = next_pc;
          valid_nx = 1'b0;
          state_nx = FETCH;
          req_nx   = 1'b1;
        end
      end
      ERR: begin
        valid_nx = 1'b0;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized checks of instr_fetch against a PC/IR reference model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ack, branch, jump, zero, done;
  logic [31:0] imem_rdata;

  logic        imem_req, instr_valid, fetch_err;
  logic [31:0] imem_addr, instr, pc, pc_plus4;
  logic [5:0]  op;

  logic        h_req, h_valid, h_err;
  logic [31:0] h_addr, h_instr, h_pc, h_pc_plus4;
  logic [5:0]  h_op;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .branch(branch), .jump(jump),
    .zero(zero), .done(done), .instr(instr), .op(op), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_err(fetch_err)
  );

  // Second instance with a high reset PC so the jump keeps the upper PC nibble
  instr_fetch #(.RESET_PC(32'h1000_0010), .TIMEOUT(16)) u_dut_hi (
    .clk(clk), .rst(rst), .imem_req(h_req), .imem_addr(h_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .branch(branch), .jump(jump),
    .zero(zero), .done(done), .instr(h_instr), .op(h_op), .instr_valid(h_valid),
    .pc(h_pc), .pc_plus4(h_pc_plus4), .fetch_err(h_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_ack = 1'b0; branch = 1'b0; jump = 1'b0; zero = 1'b0; done = 1'b0;
  endtask

  // Reference next-PC from the architectural rules, in plain arithmetic
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                             input logic b, input logic j, input logic z);
    logic [31:0] p4;
    int          off;
    p4 = p + 32'd4;
    if (j) return (p4 & 32'hF000_0000) | ((w % 32'h0400_0000) * 32'd4);
    if (b && z) begin
      off = $signed(w[15:0]);
      return p4 + 32'(off * 4);
    end
    return p4;
  endfunction

  // Zero-wait fetch of w followed by an immediate commit
  task automatic fetch_exec(input logic [31:0] w, input logic b, input logic j,
                            input logic z, input logic [31:0] exp_pc, input string tag);
    imem_ack = 1'b1; imem_rdata = w;
    step();
    chk({tag, "_ir"}, instr, w);
    imem_ack = 1'b0; branch = b; jump = j; zero = z; done = 1'b1;
    step();
    idle_inputs();
    chk({tag, "_pc"}, pc, exp_pc);
    chk({tag, "_req"}, 32'(imem_req), 32'd1);
  endtask

  initial begin
    logic [31:0] pc_m, w, w5;
    logic        b, j, z;
    int          lat, ex;

    rst = 1'b1; imem_rdata = '0;
    idle_inputs();
    repeat (2) step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_req", 32'(imem_req), 32'd0);
    step();
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, 32'h0);

    // T4: jump with branch also asserted; jump wins, upper nibble kept
    imem_ack = 1'b1; imem_rdata = 32'h0800_0040;
    step();
    chk("t4_valid", 32'(instr_valid), 32'd1);
    chk("t4_op", 32'(op), 32'd2);
    chk("t4_h_ir", h_instr, 32'h0800_0040);
    chk("t4_h_op", 32'(h_op), 32'd2);
    chk("t4_h_req", 32'(h_req), 32'd0);
    imem_ack = 1'b0; jump = 1'b1; branch = 1'b1; zero = 1'b1; done = 1'b1;
    step();
    idle_inputs();
    chk("t4_h_pc", h_pc, 32'h1000_0100);
    chk("t4_h_addr", h_addr, 32'h1000_0100);
    chk("t4_h_p4", h_pc_plus4, 32'h1000_0104);
    chk("t4_h_valid", 32'(h_valid), 32'd0);
    chk("t4_pc", pc, 32'h0000_0100);
    chk("t4_valid0", 32'(instr_valid), 32'd0);

    // T1: reset mid-EXEC, then a late ack while in IDLE
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 1'b0;
    chk("t1_exec", 32'(instr_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("t1_pc", pc, 32'h0);
    chk("t1_valid", 32'(instr_valid), 32'd0);
    chk("t1_req", 32'(imem_req), 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    rst = 1'b0;
    step();
    imem_ack = 1'b0;
    chk("t1_late_valid", 32'(instr_valid), 32'd0);
    chk("t1_late_ir", instr, 32'h0);
    chk("t1_req2", 32'(imem_req), 32'd1);
    chk("t1_addr2", imem_addr, 32'h0);

    // T2: LW, sequential advance
    imem_ack = 1'b1; imem_rdata = 32'h8C01_0004;
    step();
    imem_ack = 1'b0;
    chk("t2_op", 32'(op), 32'd35);
    chk("t2_p4", pc_plus4, 32'd4);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("t2_addr", imem_addr, 32'd4);
    chk("t2_req", 32'(imem_req), 32'd1);

    // T3: BEQ at pc 8, taken then not taken
    fetch_exec(32'h0, 1'b0, 1'b0, 1'b0, 32'd8, "t3_nop");
    fetch_exec(32'h1022_FFFD, 1'b1, 1'b0, 1'b1, 32'd0, "t3_taken");
    fetch_exec(32'h0, 1'b0, 1'b0, 1'b0, 32'd4, "t3_nop1");
    fetch_exec(32'h0, 1'b0, 1'b0, 1'b0, 32'd8, "t3_nop2");
    fetch_exec(32'h1022_FFFD, 1'b1, 1'b0, 1'b0, 32'd12, "t3_nt");

    // T5: five wait states with spurious done
    w5 = 32'hAC22_0010;
    done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_addr", imem_addr, 32'd12);
      chk("t5_req", 32'(imem_req), 32'd1);
      chk("t5_valid", 32'(instr_valid), 32'd0);
    end
    done = 1'b0; imem_ack = 1'b1; imem_rdata = w5;
    step();
    imem_ack = 1'b0;
    chk("t5_ir", instr, w5);
    chk("t5_valid1", 32'(instr_valid), 32'd1);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("t5_pc", pc, 32'd16);

    // Wrap: branch back to 0xFFFF_FFFC, then +4 wraps to 0
    fetch_exec(32'h1000_FFFA, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, "wrap_br");
    chk("wrap_p4", pc_plus4, 32'h0);
    fetch_exec(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, "wrap_seq");

    // Randomized instruction stream against the reference model
    pc_m = 32'h0;
    for (int n = 0; n < 200; n++) begin
      w   = $urandom;
      lat = $urandom_range(0, 5);
      for (int i = 0; i < lat; i++) begin
        done = 1'($urandom_range(0, 1));
        step();
        chk("r_wait_addr", imem_addr, pc_m);
        chk("r_wait_valid", 32'(instr_valid), 32'd0);
      end
      done = 1'($urandom_range(0, 1));
      imem_ack = 1'b1; imem_rdata = w;
      step();
      chk("r_ir", instr, w);
      chk("r_op", 32'(op), 32'(w >> 26));
      ex = $urandom_range(0, 3);
      for (int i = 0; i < ex; i++) begin
        done = 1'b0;
        imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
        branch = 1'($urandom_range(0, 1)); jump = 1'($urandom_range(0, 1));
        zero = 1'($urandom_range(0, 1));
        step();
        chk("r_hold_ir", instr, w);
        chk("r_hold_req", 32'(imem_req), 32'd0);
      end
      b = 1'($urandom_range(0, 1)); j = 1'($urandom_range(0, 3) == 0);
      z = 1'($urandom_range(0, 1));
      imem_ack = 1'b0; branch = b; jump = j; zero = z; done = 1'b1;
      step();
      idle_inputs();
      pc_m = model_next(pc_m, w, b, j, z);
      chk("r_pc", pc, pc_m);
      chk("r_valid", 32'(instr_valid), 32'd0);
    end

    // T6: timeout after 16 FETCH cycles, sticky until reset
    rst = 1'b1;
    #1;
    rst = 1'b0;
    step();
    for (int i = 1; i < 16; i++) begin
      step();
      chk("t6_err0", 32'(fetch_err), 32'd0);
      chk("t6_req", 32'(imem_req), 32'd1);
    end
    step();
    chk("t6_err", 32'(fetch_err), 32'd1);
    chk("t6_h_err", 32'(h_err), 32'd1);
    chk("t6_req0", 32'(imem_req), 32'd0);
    imem_ack = 1'b1; done = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    repeat (4) step();
    idle_inputs();
    chk("t6_sticky", 32'(fetch_err), 32'd1);
    chk("t6_valid", 32'(instr_valid), 32'd0);
    chk("t6_pc", pc, 32'h0);
    chk("t6_req1", 32'(imem_req), 32'd0);
    rst = 1'b1;
    #1;
    chk("t6_clr", 32'(fetch_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
